// File: rtl/reorder_buffer_if.sv
// Reorder buffer bundle: flush, decode-side allocation, execute-side completion,
// in-order commit and occupancy status.
interface reorder_buffer_if #(
  parameter int TW = 3
);
  logic          flush;
  logic          d_valid;
  logic [31:0]   d_pc;
  logic [4:0]    d_dest;
  logic          d_regwrite;
  logic [TW-1:0] d_tag;
  logic          full;
  logic          empty;
  logic          w_valid;
  logic [TW-1:0] w_tag;
  logic [31:0]   w_result;
  logic          c_valid;
  logic [31:0]   c_pc;
  logic [4:0]    c_dest;
  logic [31:0]   c_data;
  logic          c_regwrite;
  logic [TW:0]   count;

  modport master (
    output flush, d_valid, d_pc, d_dest, d_regwrite, w_valid, w_tag, w_result,
    input  d_tag, full, empty, c_valid, c_pc, c_dest, c_data, c_regwrite, count
  );

  modport slave (
    input  flush, d_valid, d_pc, d_dest, d_regwrite, w_valid, w_tag, w_result,
    output d_tag, full, empty, c_valid, c_pc, c_dest, c_data, c_regwrite, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at tail, accepts out-of-order completions,
// retires one completed entry per cycle strictly from head.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TW    = 3
) (
  input logic              clk,
  input logic              rst,
  reorder_buffer_if.slave  rob
);
  localparam logic [TW:0] FULL_CNT = (TW+1)'(DEPTH);

  logic [TW-1:0]  head;
  logic [TW-1:0]  tail;
  logic [TW:0]    cnt;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] done;
  logic [31:0]    pc_mem  [DEPTH];
  logic [4:0]     dest_mem[DEPTH];
  logic [31:0]    res_mem [DEPTH];
  logic [DEPTH-1:0] rw_mem;

  logic        full;
  logic        alloc;
  logic        complete;
  logic        retire;
  logic        c_valid_q;
  logic [31:0] c_pc_q;
  logic [4:0]  c_dest_q;
  logic [31:0] c_data_q;
  logic        c_regwrite_q;

  // Fullness comes from the pre-edge count, so a same-cycle retire never makes room.
  assign full     = (cnt == FULL_CNT);
  assign alloc    = rob.d_valid && !full && !rob.flush;
  assign complete = rob.w_valid && busy[rob.w_tag] && !rob.flush;
  assign retire   = busy[head] && done[head];

  assign rob.d_tag      = tail;
  assign rob.full       = full;
  assign rob.empty      = (cnt == '0);
  assign rob.count      = cnt;
  assign rob.c_valid    = c_valid_q;
  assign rob.c_pc       = c_pc_q;
  assign rob.c_dest     = c_dest_q;
  assign rob.c_data     = c_data_q;
  assign rob.c_regwrite = c_regwrite_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      busy         <= '0;
      done         <= '0;
      c_valid_q    <= 1'b0;
      c_pc_q       <= '0;
      c_dest_q     <= '0;
      c_data_q     <= '0;
      c_regwrite_q <= 1'b0;
    end else if (rob.flush) begin
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      busy         <= '0;
      done         <= '0;
      c_valid_q    <= 1'b0;
      c_regwrite_q <= 1'b0;
    end else begin
      if (complete)
        done[rob.w_tag] <= 1'b1;
      // Retire clears head after any completion write so a stale done cannot linger.
      if (retire) begin
        busy[head]   <= 1'b0;
        done[head]   <= 1'b0;
        head         <= head + TW'(1);
        c_valid_q    <= 1'b1;
        c_pc_q       <= pc_mem[head];
        c_dest_q     <= dest_mem[head];
        c_data_q     <= res_mem[head];
        c_regwrite_q <= rw_mem[head];
      end else begin
        c_valid_q    <= 1'b0;
        c_regwrite_q <= 1'b0;
      end
      if (alloc) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= tail + TW'(1);
      end
      case ({alloc, retire})
        2'b10:   cnt <= cnt + (TW+1)'(1);
        2'b01:   cnt <= cnt - (TW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset; busy/done decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_mem[tail]   <= rob.d_pc;
      dest_mem[tail] <= rob.d_dest;
      rw_mem[tail]   <= rob.d_regwrite;
    end
    if (complete)
      res_mem[rob.w_tag] <= rob.w_result;
  end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter: DEPTH, default 8, number of entries (power of two).
REQ-002 Parameter: TW, default 3, tag/pointer width, equal to log2(DEPTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all entries.
REQ-006 d_valid  input  1  allocation request from decode/issue side.
REQ-007 d_pc  input  32  PC of instruction being allocated.
REQ-008 d_dest  input  5  destination register address.
REQ-009 d_regwrite  input  1  instruction writes d_dest.
REQ-010 d_tag  output  TW  tag for this allocation, equal to tail pointer (combinational).
REQ-011 full  output  1  count == DEPTH (combinational from registered count).
REQ-012 empty  output  1  count == 0.
REQ-013 w_valid  input  1  execute-completion strobe.
REQ-014 w_tag  input  TW  tag of completing instruction.
REQ-015 w_result  input  32  result value.
REQ-016 c_valid  output  1  registered commit pulse, one cycle per retired entry.
REQ-017 c_pc  output  32  PC of retired entry.
REQ-018 c_dest  output  5  destination of retired entry.
REQ-019 c_data  output  32  result of retired entry.
REQ-020 c_regwrite  output  1  retired entry writes register file; 0 whenever c_valid is 0.
REQ-021 count  output  TW+1  current occupancy.

Function
REQ-022 Per entry state: busy, done, pc, dest, regwrite, result.
REQ-023 Allocation accepted when d_valid && !full: entry[tail] busy=1, done=0, fields captured; tail increments modulo DEPTH.
REQ-024 d_valid while full is ignored: no state change, no error flag.
REQ-025 Completion: w_valid with entry[w_tag].busy=1 sets done=1 and stores w_result; w_valid to a non-busy entry is ignored.
REQ-026 Completions arrive in any order; at most one per cycle.
REQ-027 Commit: at each edge, if entry[head] is busy and done (registered values), drive c_valid=1 with its fields, clear busy/done, and increment head modulo DEPTH; otherwise c_valid=0, c_regwrite=0.
REQ-028 At most one commit per cycle; retirement is strictly in allocation order.
REQ-029 Latency: completion sampled at edge k commits no earlier than edge k+1; no same-cycle bypass of w_result to commit.
REQ-030 count: +1 on accepted allocation, -1 on commit, unchanged when both occur at the same edge.
REQ-031 full is evaluated from count before the edge; a commit in the same cycle does not free space for that cycle's allocation.
REQ-032 Pointer wrap 7->0 (DEPTH-1->0) is seamless; no loss or duplication across the wrap.
REQ-033 Completion targeting the entry being allocated at the same edge is ignored (entry not yet busy).
REQ-034 Completion to head at the same edge as a commit of head is impossible by REQ-029 and needs no handling.
REQ-035 flush: head=tail=0, count=0, all busy/done cleared, c_valid=0, c_regwrite=0 at the next edge; d_valid and w_valid in that cycle are ignored.

Reset
REQ-036 rst high at an edge: head=tail=0, count=0, all busy/done=0, c_valid=0, c_pc=0, c_dest=0, c_data=0, c_regwrite=0.
REQ-037 rst takes priority over flush, allocation, completion and commit; entry payload fields need not be cleared.
REQ-038 Reset asserted mid-operation discards all in-flight entries; after release, empty=1 and d_tag=0.

Verification
REQ-039 Allocate 3 (pc 0x10/0x14/0x18), complete tag 2, then 0, then 1 -> c_valid pulses in order 0x10, 0x14, 0x18, the first pulse one cycle after tag 0 completes.
REQ-040 Allocate 8 entries -> full=1, count=8; 9th d_valid ignored; complete tag 0 -> commit, count=7, full=0.
REQ-041 Steady state with one allocation, completion and commit per cycle for 20 cycles -> tags wrap 7->0 twice, count constant, commit PCs in issue order.
REQ-042 Allocation and commit at the same edge while count=8 -> allocation rejected, count=7 afterwards.
REQ-043 4 busy entries, 2 done, assert flush -> next cycle count=0, empty=1, c_valid=0; late w_valid for an old tag ignored.
REQ-044 rst asserted with 5 entries busy and a commit pending -> next cycle c_valid=0, count=0, d_tag=0.
